console_uart: RTL

Memory-mapped console device on the CPU data bus, replacing the simulation-only character sink and halt command with synthesizable logic. Decodes a 16-byte window at `0xa0000000`. Bytes written to TXDATA go into a FIFO and are serialized as 8N1 UART frames on `txd`. A write to HLT raises a sticky `hlt` flag, and STATUS is readable. It sits downstream of `CPUCore`, next to main memory, behind the bus address decode.

---
 rtl/console_uart_pkg.sv | 36 +++
 rtl/console_uart_sync_fifo.sv | 64 ++++++
 rtl/console_uart.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/console_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_uart_pkg : bus encodings, register map and FSM states            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package console_uart_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_R    = 2'b01,
        MEM_W    = 2'b10,
        MEM_X    = 2'b11
    } mem_access_t;

    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10
    } mem_len_t;

    localparam logic [3:0] c_REG_HLT    = 4'h0;
    localparam logic [3:0] c_REG_TXDATA = 4'h1;
    localparam logic [3:0] c_REG_STATUS = 4'h4;

    localparam int c_STAT_EMPTY = 0;
    localparam int c_STAT_FULL  = 1;
    localparam int c_STAT_BUSY  = 2;
    localparam int c_STAT_COUNT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/console_uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock first-word-fallthrough FIFO                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/console_uart.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | console_uart : memory-mapped console (8N1 TX FIFO, halt flag, status)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module console_uart
    import console_uart_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'ha0000000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  logic [31:0] db_dataOut,
    input  mem_access_t db_accessType,
    input  mem_len_t    db_memLen,
    output logic        db_ready,
    output logic [31:0] db_dataIn,
    output logic        txd,
    output logic        hlt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] c_BAUD_MAX = BW'(CLK_DIV - 1);

    logic          w_sel, w_wr, w_rd, w_push, w_pop;
    logic          w_full, w_empty, w_baud_end;
    logic [7:0]    w_dout;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_unused_bits;

    logic [1:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bitidx;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_hlt;
    logic [31:0]   r_rdata;

    assign w_sel    = (db_addr[31:4] == BASE[31:4]);
    assign w_wr     = w_sel && (db_accessType == MEM_W);
    assign w_rd     = w_sel && (db_accessType == MEM_R);
    assign db_ready = !(w_wr && (db_addr[3:0] == c_REG_TXDATA) && w_full);
    assign w_push   = w_wr && (db_addr[3:0] == c_REG_TXDATA) && !w_full;

    assign w_baud_end = (r_baud == c_BAUD_MAX);
    // IDLE pops immediately; STOP pops on its last cycle so frames abut.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));

    assign w_unused_bits = ^{db_memLen, db_dataOut[31:8]};

    always_comb begin
        w_status = '0;
        w_status[c_STAT_EMPTY]       = w_empty;
        w_status[c_STAT_FULL]        = w_full;
        w_status[c_STAT_BUSY]        = (r_state != ST_IDLE);
        w_status[c_STAT_COUNT +: CW] = w_count;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (w_push),
        .din   (db_dataOut[7:0]),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_hlt   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wr && (db_addr[3:0] == c_REG_HLT)) begin
                r_hlt <= 1'b1;
            end
            if (w_rd) begin
                r_rdata <= (db_addr[3:0] == c_REG_STATUS) ? w_status : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_shift <= w_dout;
                        r_txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud   <= '0;
                        r_bitidx <= '0;
                        r_state  <= ST_DATA;
                        r_txd    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud   <= '0;
                        r_bitidx <= r_bitidx + 1'b1;
                        r_shift  <= {1'b0, r_shift[7:1]};
                        if (r_bitidx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_shift <= w_dout;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    assign txd       = r_txd;
    assign hlt       = r_hlt;
    assign db_dataIn = r_rdata;

endmodule
`default_nettype wire
